// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin share of one 32-bit adder among N_REQ
// requesters, registered sum returned on one tagged valid/ready channel.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_valid_i       per-requester request valid
//   req_ready_o       per-requester accept (one-hot or zero)
//   req_a_i, req_b_i  packed operands, requester i at [32i+31:32i]
//   rsp_valid_o       response valid
//   rsp_ready_i       response consumer ready
//   rsp_id_o          requester index of the response
//   rsp_data_o        registered A+B mod 2^32
//   op_cnt_o          completed-response count, wraps at 16 bits
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*32-1:0] req_a_i,
  input  logic [N_REQ*32-1:0] req_b_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [31:0]        rsp_data_o,
  output logic [15:0]        op_cnt_o
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic [15:0]      op_cnt_q, op_cnt_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  gid;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic             accept;
  logic             req_xfer;
  logic             rsp_xfer;
  logic [31:0]      a_sel;
  logic [31:0]      b_sel;
  logic [31:0]      sum;

  // Search from ptr upward, wrapping; first valid requester wins.
  always_comb begin
    grant = '0;
    gid   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid_i[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = idx;
      end
    end
  end

  // Grant-driven operand mux; operands never reach control logic.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | req_a_i[32*i +: 32];
        b_sel = b_sel | req_b_i[32*i +: 32];
      end
    end
  end

  // The single shared adder; carry-out is dropped.
  assign sum = a_sel + b_sel;

  assign accept      = (!rsp_valid_q || rsp_ready_i) && !rst_i;
  assign req_ready_o = grant & {N_REQ{accept}};
  assign req_xfer    = found && accept;
  assign rsp_xfer    = rsp_valid_q && rsp_ready_i;

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    op_cnt_d    = op_cnt_q;
    if (rsp_xfer) begin
      op_cnt_d    = op_cnt_q + 16'd1;
      rsp_valid_d = 1'b0;
    end
    if (req_xfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gid;
      rsp_data_d  = sum;
      if (gid == ID_W'(N_REQ - 1)) ptr_d = '0;
      else                         ptr_d = gid + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      op_cnt_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed self-checking bench for adder_arbiter.
// Inputs change 1ns after each rising edge; outputs checked there.
module tb_adder_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   vld;
  logic [N-1:0]   rdy;
  logic [N*32-1:0] a;
  logic [N*32-1:0] b;
  logic           rsp_vld;
  logic           rsp_rdy;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_data;
  logic [15:0]    cnt;

  int n_chk;
  int n_err;

  adder_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (vld),
    .req_ready_o (rdy),
    .req_a_i     (a),
    .req_b_i     (b),
    .rsp_valid_o (rsp_vld),
    .rsp_ready_i (rsp_rdy),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .op_cnt_o    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [31:0] av,
                        input logic [31:0] bv);
    a[32*i +: 32] = av;
    b[32*i +: 32] = bv;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b1;
    vld     = '1;
    rsp_rdy = 1'b1;
    a       = '0;
    b       = '0;

    // Reset held 2 cycles with everyone valid
    tick();
    chk("rst_ready", 32'(rdy), 32'h0);
    tick();
    chk("rst_ready2", 32'(rdy), 32'h0);
    chk("rst_valid", 32'(rsp_vld), 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    rst = 1'b0;
    vld = '0;
    tick();
    chk("post_rst_valid", 32'(rsp_vld), 32'h0);

    // Single op from requester 2
    set_op(2, 32'h0000_0004, 32'h0040_0000);
    vld = 4'b0100;
    #1;
    chk("single_ready", 32'(rdy), 32'h4);
    tick();
    vld = '0;
    chk("single_valid", 32'(rsp_vld), 32'h1);
    chk("single_id", 32'(rsp_id), 32'h2);
    chk("single_data", rsp_data, 32'h0040_0004);
    tick();
    chk("single_drain", 32'(rsp_vld), 32'h0);
    chk("single_cnt", 32'(cnt), 32'h1);
    chk("single_hold", rsp_data, 32'h0040_0004);

    // Carry-out discarded; ptr=3, only requester 0 valid
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0002);
    vld = 4'b0001;
    #1;
    chk("wrap_ready", 32'(rdy), 32'h1);
    tick();
    vld = '0;
    chk("wrap_data", rsp_data, 32'h0000_0001);
    chk("wrap_id", 32'(rsp_id), 32'h0);
    tick();
    chk("wrap_cnt", 32'(cnt), 32'h2);

    // Round-robin from reset, all valid, no bubbles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 32'(i) * 32'h10, 32'h1000);
    vld = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_valid", 32'(rsp_vld), 32'h1);
      chk("rr_id", 32'(rsp_id), 32'(k % N));
      chk("rr_data", rsp_data, 32'h1000 + 32'(k % N) * 32'h10);
    end
    chk("rr_cnt", 32'(cnt), 32'd5);

    // Backpressure with id 1 pending; ptr=2
    rsp_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(rdy), 32'h0);
      tick();
      chk("bp_id", 32'(rsp_id), 32'h1);
      chk("bp_data", rsp_data, 32'h1010);
      chk("bp_cnt", 32'(cnt), 32'd5);
      chk("bp_valid", 32'(rsp_vld), 32'h1);
    end
    rsp_rdy = 1'b1;
    #1;
    chk("bp_release_ready", 32'(rdy), 32'h4);
    tick();
    vld = '0;
    chk("bp_next_id", 32'(rsp_id), 32'h2);
    chk("bp_next_cnt", 32'(cnt), 32'd6);
    tick();
    chk("bp_drain_cnt", 32'(cnt), 32'd7);
    chk("bp_drain_valid", 32'(rsp_vld), 32'h0);

    // Counter wrap: 65535 completions, then one more
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vld = 4'b1000;
    for (int k = 0; k < 65536; k++) tick();
    chk("cnt_full", 32'(cnt), 32'h0000_FFFF);
    chk("cnt_full_valid", 32'(rsp_vld), 32'h1);
    vld = '0;
    tick();
    chk("cnt_wrap", 32'(cnt), 32'h0);
    chk("cnt_wrap_valid", 32'(rsp_vld), 32'h0);

    // Mid-op reset: pending response from req 1, ptr=2
    set_op(1, 32'h0000_0100, 32'h0000_0023);
    set_op(3, 32'h0000_0300, 32'h0000_0001);
    rsp_rdy = 1'b0;
    vld = 4'b0010;
    tick();
    chk("mid_pending", 32'(rsp_vld), 32'h1);
    chk("mid_pending_data", rsp_data, 32'h0000_0123);
    vld = 4'b1010;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_drop_valid", 32'(rsp_vld), 32'h0);
    chk("mid_drop_cnt", 32'(cnt), 32'h0);
    chk("mid_drop_data", rsp_data, 32'h0);
    rsp_rdy = 1'b1;
    #1;
    chk("mid_ready", 32'(rdy), 32'h2);
    tick();
    vld = '0;
    chk("mid_id", 32'(rsp_id), 32'h1);
    chk("mid_data", rsp_data, 32'h0000_0123);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
